// File: rtl/cpu_debug_pkg.sv
// cpu_debug_pkg
// Shared definitions for the halt-triggered state dumper: default widths,
// the HALT instruction word, dump FSM state encoding, record kind and the
// record layout seen by the downstream trace/UART logger.
package cpu_debug_pkg;

    localparam int DUMP_DATA_W = 16;
    localparam int DUMP_MEM_AW = 16;
    localparam int DUMP_REG_AW = 4;

    // opcode 11100, all operand fields zero
    localparam logic [15:0] HALT_OPCODE = 16'hE000;

    typedef enum logic [2:0] {
        DS_IDLE    = 3'd0,
        DS_REG     = 3'd1,
        DS_MEM_REQ = 3'd2,
        DS_MEM_CHK = 3'd3,
        DS_EMIT    = 3'd4,
        DS_DONE    = 3'd5
    } dump_state_t;

    typedef enum logic {
        REC_REG = 1'b0,
        REC_MEM = 1'b1
    } rec_kind_t;

    typedef struct packed {
        rec_kind_t               kind;
        logic [DUMP_MEM_AW-1:0]  addr;
        logic [DUMP_DATA_W-1:0]  data;
    } dump_rec_t;

endpackage

// File: rtl/halt_state_dumper_if.sv
// halt_state_dumper_if
// Record stream from the dumper to the trace/UART logger.
//   out_valid  record valid (master)
//   out_ready  consumer accepts when out_valid && out_ready (slave)
//   out_kind   0 = register record, 1 = memory record
//   out_addr   register index (zero-extended) or memory address
//   out_data   record payload
interface halt_state_dumper_if #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 16
);
    logic              out_valid;
    logic              out_ready;
    logic              out_kind;
    logic [MEM_AW-1:0] out_addr;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_kind, output out_addr,
                    output out_data, input out_ready);
    modport slave  (input out_valid, input out_kind, input out_addr,
                    input out_data, output out_ready);
endinterface

// File: rtl/dump_out_reg.sv
// dump_out_reg
// Holding register for one output record plus its valid flag.
//   load/load_*  capture a new record and raise valid
//   ready        consumer ready
//   valid/kind/addr/data  registered record outputs, stable until accepted
//   accept       valid && ready, the handshake completes this cycle
// Outputs come straight from flops, so ready never reaches them
// combinationally.
module dump_out_reg #(
    parameter int DATA_W = 16,
    parameter int MEM_AW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_kind,
    input  logic [MEM_AW-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic              kind,
    output logic [MEM_AW-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              accept
);

    assign accept = valid && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            kind  <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            kind  <= load_kind;
            addr  <= load_addr;
            data  <= load_data;
        end else if (accept) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/halt_state_dumper.sv
// halt_state_dumper
// Watches the fetched instruction for HALT; on HALT freezes the cpu and
// streams r0..r15 followed by every non-zero data-memory word.
//   clk, reset(active-low async)
//   dump_en      arms HALT detection, drop to leave DONE
//   instr        instruction fetched by cpu
//   cpu_freeze   holds the cpu from the first dump cycle until re-armed
//   reg_rd_*     combinational register-file read port
//   mem_rd_*     data-memory read port, data one cycle after mem_rd_en
//   dump_out     record stream (halt_state_dumper_if master)
//   busy, done   dump in progress / complete
//   rec_count    records accepted this dump
//
// state    | meaning
// ---------+-------------------------------------------------------
// IDLE     | waiting for dump_en && HALT
// REG      | emitting register idx, advance on accept
// MEM_REQ  | read strobe for memory word addr
// MEM_CHK  | read data present; load record or skip zero word
// EMIT     | holding memory record until accepted
// DONE     | dump finished, cpu still frozen until dump_en drops
module halt_state_dumper #(
    parameter int          DATA_W      = cpu_debug_pkg::DUMP_DATA_W,
    parameter int          MEM_AW      = cpu_debug_pkg::DUMP_MEM_AW,
    parameter int          REG_AW      = cpu_debug_pkg::DUMP_REG_AW,
    parameter logic [15:0] HALT_OPCODE = cpu_debug_pkg::HALT_OPCODE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dump_en,
    input  logic [15:0]         instr,
    output logic                cpu_freeze,
    output logic [REG_AW-1:0]   reg_rd_addr,
    input  logic [DATA_W-1:0]   reg_rd_data,
    output logic                mem_rd_en,
    output logic [MEM_AW-1:0]   mem_rd_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                busy,
    output logic                done,
    output logic [MEM_AW:0]     rec_count,
    halt_state_dumper_if.master dump_out
);
    import cpu_debug_pkg::*;

    localparam logic [2:0] S_IDLE    = DS_IDLE;
    localparam logic [2:0] S_REG     = DS_REG;
    localparam logic [2:0] S_MEM_REQ = DS_MEM_REQ;
    localparam logic [2:0] S_MEM_CHK = DS_MEM_CHK;
    localparam logic [2:0] S_EMIT    = DS_EMIT;
    localparam logic [2:0] S_DONE    = DS_DONE;

    localparam logic [REG_AW-1:0] IDX_LAST    = '1;
    // address one below the top; reaching it arms last_word for the next step
    localparam logic [MEM_AW-1:0] ADDR_PENULT = {{(MEM_AW-1){1'b1}}, 1'b0};

    logic [2:0]        state;
    logic [REG_AW-1:0] idx;
    logic [MEM_AW-1:0] addr;
    logic              last_word;

    logic              load;
    logic              load_kind;
    logic [MEM_AW-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              accept;
    logic              mem_hit;
    logic              advance;

    assign mem_hit = (mem_rd_data != '0);
    // move past the current memory word: skipped zero or accepted record
    assign advance = ((state == S_MEM_CHK) && !mem_hit) ||
                     ((state == S_EMIT) && accept);

    always_comb begin
        load      = 1'b0;
        load_kind = REC_REG;
        load_addr = '0;
        load_data = '0;
        case (state)
            S_REG: begin
                if (!dump_out.out_valid) begin
                    load      = 1'b1;
                    load_kind = REC_REG;
                    load_addr = MEM_AW'(idx);
                    load_data = reg_rd_data;
                end
            end
            S_MEM_CHK: begin
                if (mem_hit) begin
                    load      = 1'b1;
                    load_kind = REC_MEM;
                    load_addr = addr;
                    load_data = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            addr      <= '0;
            last_word <= 1'b0;
            rec_count <= '0;
        end else begin
            if (accept) begin
                rec_count <= rec_count + 1'b1;
            end
            if (advance) begin
                if (last_word) begin
                    state <= S_DONE;
                end else begin
                    addr      <= addr + 1'b1;
                    last_word <= (addr == ADDR_PENULT);
                    state     <= S_MEM_REQ;
                end
            end
            case (state)
                S_IDLE: begin
                    if (dump_en && (instr == HALT_OPCODE)) begin
                        state     <= S_REG;
                        idx       <= '0;
                        addr      <= '0;
                        last_word <= 1'b0;
                        rec_count <= '0;
                    end
                end
                S_REG: begin
                    if (accept) begin
                        if (idx == IDX_LAST) begin
                            state <= S_MEM_REQ;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_MEM_REQ: state <= S_MEM_CHK;
                S_MEM_CHK: begin
                    if (mem_hit) begin
                        state <= S_EMIT;
                    end
                end
                S_EMIT: ;
                S_DONE: begin
                    if (!dump_en) begin
                        state     <= S_IDLE;
                        idx       <= '0;
                        addr      <= '0;
                        last_word <= 1'b0;
                        rec_count <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cpu_freeze  = (state != S_IDLE);
    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);
    assign mem_rd_en   = (state == S_MEM_REQ);
    assign mem_rd_addr = addr;
    assign reg_rd_addr = idx;

    dump_out_reg #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_kind (load_kind),
        .load_addr (load_addr),
        .load_data (load_data),
        .ready     (dump_out.out_ready),
        .valid     (dump_out.out_valid),
        .kind      (dump_out.out_kind),
        .addr      (dump_out.out_addr),
        .data      (dump_out.out_data),
        .accept    (accept)
    );

endmodule

// File: tb/tb_halt_state_dumper.sv
// tb_halt_state_dumper
// Scenario tasks around halt_state_dumper with a reduced memory space so a
// full scan stays short. Expected records come from the register/memory
// arrays: 16 register records, then every non-zero word in address order.
module tb_halt_state_dumper;
    import cpu_debug_pkg::*;

    localparam int DW     = 16;
    localparam int AW     = 10;
    localparam int RW     = 4;
    localparam int NWORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          dump_en = 1'b0;
    logic [15:0]   instr = 16'h0000;
    logic          cpu_freeze;
    logic [RW-1:0] reg_rd_addr;
    logic [DW-1:0] reg_rd_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          busy;
    logic          done;
    logic [AW:0]   rec_count;

    halt_state_dumper_if #(.DATA_W(DW), .MEM_AW(AW)) dut_if ();

    halt_state_dumper #(
        .DATA_W(DW), .MEM_AW(AW), .REG_AW(RW), .HALT_OPCODE(16'hE000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dump_en     (dump_en),
        .instr       (instr),
        .cpu_freeze  (cpu_freeze),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .busy        (busy),
        .done        (done),
        .rec_count   (rec_count),
        .dump_out    (dut_if)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] regs [16];
    logic [DW-1:0] mem  [NWORDS];

    assign reg_rd_data = regs[reg_rd_addr];
    // memory answers one cycle after the strobe; garbage otherwise
    always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : DW'($urandom);

    int n_cmp = 0;
    int n_bad = 0;

    dump_rec_t got[$];
    dump_rec_t exp_q[$];
    int        rd_log[$];
    int        rmode = 0;
    int        stab_viol = 0;
    int        rd_viol = 0;

    // consumer: drives ready, collects accepted records and memory reads
    initial begin : consumer
        bit            prev_hold;
        bit            r;
        logic          pk;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int            phase;
        prev_hold = 1'b0;
        phase = 0;
        dut_if.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_hold = 1'b0;
                dut_if.out_ready = 1'b0;
            end else begin
                if (prev_hold && !(dut_if.out_valid === 1'b1 && dut_if.out_kind === pk &&
                                   dut_if.out_addr === pa && dut_if.out_data === pd))
                    stab_viol++;
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = (phase % 3 == 0);
                    2:       r = 1'($urandom_range(0, 1));
                    default: r = 1'b0;
                endcase
                phase++;
                dut_if.out_ready = r;
                if (dut_if.out_valid && r)
                    got.push_back(dump_rec_t'{rec_kind_t'(dut_if.out_kind),
                                              16'(dut_if.out_addr), dut_if.out_data});
                prev_hold = dut_if.out_valid && !r;
                pk = dut_if.out_kind;
                pa = dut_if.out_addr;
                pd = dut_if.out_data;
                if (mem_rd_en) begin
                    rd_log.push_back(int'(mem_rd_addr));
                    if (dut_if.out_valid) rd_viol++;
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic build_expected();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(dump_rec_t'{REC_REG, 16'(i), regs[i]});
        for (int a = 0; a < NWORDS; a++)
            if (mem[a] != 0) exp_q.push_back(dump_rec_t'{REC_MEM, 16'(a), mem[a]});
    endtask

    task automatic clear_mem();
        for (int a = 0; a < NWORDS; a++) mem[a] = '0;
    endtask

    task automatic start_dump();
        got.delete();
        rd_log.delete();
        stab_viol = 0;
        rd_viol = 0;
        @(negedge clk);
        dump_en = 1'b1;
        instr = 16'hE000;
        @(negedge clk);
        instr = 16'h1234;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({cpu_freeze, busy, done, mem_rd_en, dut_if.out_valid, dut_if.out_kind} !== 6'b0) begin
            n_bad++; $display("FAIL reset flags: got %b want 000000", {cpu_freeze, busy, done, mem_rd_en, dut_if.out_valid, dut_if.out_kind}); end
        n_cmp++; if ({rec_count, dut_if.out_addr, dut_if.out_data, mem_rd_addr, reg_rd_addr} !== '0) begin
            n_bad++; $display("FAIL reset values: rec_count %h addr %h data %h", rec_count, dut_if.out_addr, dut_if.out_data); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_regs_only();
        bit ok;
        int bad_rd;
        clear_mem();
        for (int i = 0; i < 16; i++) regs[i] = DW'(i * 3);
        rmode = 0;
        start_dump();
        n_cmp++; if ({busy, cpu_freeze} !== 2'b11) begin
            n_bad++; $display("FAIL regs_only start: busy/freeze %b want 11", {busy, cpu_freeze}); end
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL regs_only timeout: done %b want 1", done); end
        build_expected();
        n_cmp++; if (got.size() != 16) begin n_bad++; $display("FAIL regs_only count: got %0d want 16", got.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL regs_only rec[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        n_cmp++; if (rec_count !== 17'(16)) begin n_bad++; $display("FAIL regs_only rec_count: got %0d want 16", rec_count); end
        n_cmp++; if ({busy, done, cpu_freeze} !== 3'b011) begin
            n_bad++; $display("FAIL regs_only done flags: busy/done/freeze %b want 011", {busy, done, cpu_freeze}); end
        bad_rd = (rd_log.size() == NWORDS) ? 0 : 1;
        for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != i) bad_rd++;
        n_cmp++; if (bad_rd != 0) begin n_bad++; $display("FAIL regs_only scan: %0d reads, %0d errors want %0d in order", rd_log.size(), bad_rd, NWORDS); end
        dump_en = 1'b0;
        @(negedge clk);
        n_cmp++; if ({cpu_freeze, done, busy, rec_count} !== '0) begin
            n_bad++; $display("FAIL regs_only rearm: freeze %b done %b rec_count %0d want 0", cpu_freeze, done, rec_count); end
    endtask

    task automatic test_sparse_mem();
        bit ok;
        int nrd;
        clear_mem();
        for (int i = 0; i < 16; i++) regs[i] = DW'($urandom);
        mem[0] = 16'h0007;
        mem[10'h234] = 16'hBEEF;
        mem[NWORDS-1] = 16'h0001;
        rmode = 0;
        start_dump();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL sparse timeout: done %b want 1", done); end
        build_expected();
        n_cmp++; if (got.size() != 19) begin n_bad++; $display("FAIL sparse count: got %0d want 19", got.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++; if (got[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL sparse rec[%0d]: got %h want %h", i, got[i], exp_q[i]); end
        end
        if (got.size() > 0) begin
            n_cmp++; if (got[got.size()-1].addr !== 16'(NWORDS-1)) begin
                n_bad++; $display("FAIL sparse last addr: got %h want %h", got[got.size()-1].addr, NWORDS-1); end
        end
        nrd = rd_log.size();
        repeat (20) @(negedge clk);
        n_cmp++; if (rd_log.size() != NWORDS || nrd != NWORDS) begin
            n_bad++; $display("FAIL sparse wrap: reads %0d then %0d want %0d", nrd, rd_log.size(), NWORDS); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sparse done hold: got %b want 1", done); end
        dump_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok;
        for (int i = 0; i < 20; i++) mem[$urandom_range(0, NWORDS-1)] = DW'($urandom_range(1, 65535));
        regs[5] = '0;
        for (int pass = 0; pass < 2; pass++) begin
            rmode = 3;
            start_dump();
            repeat (50) @(negedge clk);
            n_cmp++; if ({dut_if.out_valid, dut_if.out_kind, dut_if.out_addr} !== {1'b1, 1'b0, AW'(0)} || rd_log.size() != 0 || busy !== 1'b1) begin
                n_bad++; $display("FAIL stall: valid %b addr %h reads %0d busy %b want 1 0 0 1", dut_if.out_valid, dut_if.out_addr, rd_log.size(), busy); end
            rmode = (pass == 0) ? 1 : 2;
            wait_done(ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp timeout: done %b want 1", done); end
            build_expected();
            n_cmp++; if (got.size() != exp_q.size()) begin n_bad++; $display("FAIL bp count: got %0d want %0d", got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                n_cmp++; if (got[i] !== exp_q[i]) begin
                    n_bad++; $display("FAIL bp rec[%0d]: got %h want %h", i, got[i], exp_q[i]); end
            end
            n_cmp++; if (stab_viol != 0 || rd_viol != 0) begin
                n_bad++; $display("FAIL bp hold: stability %0d read-while-valid %0d want 0 0", stab_viol, rd_viol); end
            n_cmp++; if (rec_count !== 17'(exp_q.size())) begin
                n_bad++; $display("FAIL bp rec_count: got %0d want %0d", rec_count, exp_q.size()); end
            dump_en = 1'b0;
            @(negedge clk);
        end
        rmode = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        rmode = 0;
        start_dump();
        hit = 1'b0;
        for (int i = 0; i < 5000 && !hit; i++) begin
            if (mem_rd_en && mem_rd_addr == AW'(10'h100)) hit = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL midreset reach: addr %h want 100", mem_rd_addr); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({cpu_freeze, busy, done, mem_rd_en, dut_if.out_valid, rec_count, dut_if.out_addr, dut_if.out_data, mem_rd_addr} !== '0) begin
            n_bad++; $display("FAIL midreset outputs: freeze %b busy %b valid %b rec_count %0d mem_addr %h want 0", cpu_freeze, busy, dut_if.out_valid, rec_count, mem_rd_addr); end
        @(negedge clk);
        reset = 1'b1;
        dump_en = 1'b0;
        @(negedge clk);
        start_dump();
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midreset timeout: done %b want 1", done); end
        build_expected();
        n_cmp++; if (got.size() == 0 || got[0] !== exp_q[0]) begin
            n_bad++; $display("FAIL midreset first: got %0d records want first %h", got.size(), exp_q[0]); end
        n_cmp++; if (got != exp_q) begin n_bad++; $display("FAIL midreset sequence: got %0d records want %0d", got.size(), exp_q.size()); end
        dump_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dump_en_gating();
        bit ok;
        bit rose;
        rose = 1'b0;
        dump_en = 1'b0;
        instr = 16'hE000;
        repeat (6) begin @(negedge clk); if (cpu_freeze || busy) rose = 1'b1; end
        n_cmp++; if (rose) begin n_bad++; $display("FAIL gating disarmed: freeze/busy rose want 0"); end
        start_dump();
        repeat (5) @(negedge clk);
        dump_en = 1'b0;
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL gating timeout: done %b want 1", done); end
        build_expected();
        n_cmp++; if (got != exp_q || rec_count !== 17'(exp_q.size())) begin
            n_bad++; $display("FAIL gating sequence: got %0d records rec_count %0d want %0d", got.size(), rec_count, exp_q.size()); end
        @(negedge clk);
        n_cmp++; if ({cpu_freeze, done, busy, rec_count} !== '0) begin
            n_bad++; $display("FAIL gating idle: freeze %b done %b busy %b rec_count %0d want 0", cpu_freeze, done, busy, rec_count); end
    endtask

    task automatic test_bad_opcode();
        bit rose;
        logic [15:0] w;
        rose = 1'b0;
        dump_en = 1'b1;
        instr = 16'hE001;
        repeat (4) begin @(negedge clk); if (cpu_freeze || busy) rose = 1'b1; end
        for (int i = 0; i < 30; i++) begin
            w = 16'($urandom);
            if (w == 16'hE000) w = 16'hE010;
            instr = w;
            @(negedge clk);
            if (cpu_freeze || busy) rose = 1'b1;
        end
        n_cmp++; if (rose) begin n_bad++; $display("FAIL bad_opcode: freeze/busy rose want 0"); end
        dump_en = 1'b0;
        instr = 16'h0000;
        @(negedge clk);
    endtask

    initial begin : main
        for (int i = 0; i < 16; i++) regs[i] = '0;
        clear_mem();
        test_reset();
        test_regs_only();
        test_sparse_mem();
        test_backpressure();
        test_reset_mid();
        test_dump_en_gating();
        test_bad_opcode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
